// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning slice:
//   - btn_state_t       : per-channel debounce state (2-bit encoding)
//   - DEBOUNCE_10MS_25M : stable-sample count for 10 ms at 25.125 MHz
//   - cnt_width()       : debounce counter width, max(1, clog2(n))
// No ports (package).
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_10MS_25M = 251250;

    // Counter must hold 0..n-1; a single cycle of qualification still needs one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchronizer, polarity normalization, debounce
// FSM with qualification counter, and (optionally) press/release pulses.
//
// Optional feature macro: BTN_CONDITIONER_EDGE_EN
//   defined   -> press_pulse / release_pulse are registered one-cycle pulses
//   undefined -> both tied to 0, pulse registers not built
//
// Ports:
//   clk           in   pixel clock, rising edge
//   rst           in   asynchronous active-high reset
//   raw           in   raw pad value, asynchronous to clk
//   level         out  debounced level, 1 = pressed (registered)
//   press_pulse   out  one-cycle pulse on accepted press
//   release_pulse out  one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25M,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    // Synchronizer resets to the idle pad level so reset never looks like a press.
    localparam logic           IDLE_RAW = ACTIVE_LOW;

    logic          sync1_r;
    logic          sync2_r;
    logic          act_s;
    btn_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;

`ifdef BTN_CONDITIONER_EDGE_EN
    logic          press_r;
    logic          release_r;
`endif

    // Two-flop synchronizer bringing the asynchronous pad into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= IDLE_RAW;
            sync2_r <= IDLE_RAW;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Normalize polarity after synchronization: 1 means "pressed".
    assign act_s = sync2_r ^ IDLE_RAW;

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive samples in the WAIT state; any opposite sample restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            level_r   <= 1'b0;
`ifdef BTN_CONDITIONER_EDGE_EN
            press_r   <= 1'b0;
            release_r <= 1'b0;
`endif
        end else begin
`ifdef BTN_CONDITIONER_EDGE_EN
            press_r   <= 1'b0;
            release_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (act_s) begin
                        state_r <= PRESS_WAIT;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                PRESS_WAIT: begin
                    if (!act_s) begin
                        state_r <= IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= PRESSED;
                        cnt_r   <= {CW{1'b0}};
                        level_r <= 1'b1;
`ifdef BTN_CONDITIONER_EDGE_EN
                        press_r <= 1'b1;
`endif
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!act_s) begin
                        state_r <= RELEASE_WAIT;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RELEASE_WAIT: begin
                    if (act_s) begin
                        state_r <= PRESSED;
                        cnt_r   <= {CW{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= IDLE;
                        cnt_r     <= {CW{1'b0}};
                        level_r   <= 1'b0;
`ifdef BTN_CONDITIONER_EDGE_EN
                        release_r <= 1'b1;
`endif
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CW{1'b0}};
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_r;

`ifdef BTN_CONDITIONER_EDGE_EN
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
`else
    assign press_pulse   = 1'b0;
    assign release_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions NUM_BTN raw, bouncing push-button pads into clean active-high
// levels in the pixel clock domain. Each channel is independent.
//
// Optional feature macro: BTN_CONDITIONER_EDGE_EN (press/release pulses;
// when undefined both pulse outputs are constant 0).
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous active-high reset
//   btn_raw      in   [NUM_BTN] raw pads, asynchronous
//   btn_level    out  [NUM_BTN] debounced level, 1 = pressed
//   btn_press    out  [NUM_BTN] one-cycle accepted-press pulse
//   btn_release  out  [NUM_BTN] one-cycle accepted-release pulse
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25M,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1,
// NUM_BTN=5). Reference model: a level changes once the normalized input,
// seen two clocks late, has differed from the current level on
// DEBOUNCE_CYCLES+1 consecutive edges.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int NB = 5;
    localparam int D  = 4;
`ifdef BTN_CONDITIONER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif
    localparam int EXP_PULSES = EDGE_EN ? 1 : 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = 5'h1f;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    btn_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [NB-1:0] m_h1, m_h2, m_level, m_press, m_rel;
    int            m_run [NB];

    // per-channel event watch
    int            edge_no;
    int            rise_edge [NB];
    int            fall_edge [NB];
    int            press_cnt [NB];
    int            rel_cnt   [NB];
    logic [NB-1:0] prev_lvl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h1    = '1;
        m_h2    = '1;
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic act;
        for (int i = 0; i < NB; i++) begin
            act        = ~m_h2[i];
            m_h2[i]    = m_h1[i];
            m_h1[i]    = btn_raw[i];
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (act != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_level[i] = act;
                    if (EDGE_EN) begin
                        if (act) m_press[i] = 1'b1;
                        else     m_rel[i]   = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic watch_start();
        edge_no = 0;
        for (int i = 0; i < NB; i++) begin
            rise_edge[i] = 0;
            fall_edge[i] = 0;
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        prev_lvl = btn_level;
    endtask

    // Called at a negedge: drive raw, take one rising edge, compare at next negedge.
    task automatic step(input logic [NB-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_step();
        edge_no++;
        @(negedge clk);
        check("level",   {27'd0, btn_level},   {27'd0, m_level});
        check("press",   {27'd0, btn_press},   {27'd0, m_press});
        check("release", {27'd0, btn_release}, {27'd0, m_rel});
        for (int i = 0; i < NB; i++) begin
            if (btn_level[i] && !prev_lvl[i] && rise_edge[i] == 0) rise_edge[i] = edge_no;
            if (!btn_level[i] && prev_lvl[i] && fall_edge[i] == 0) fall_edge[i] = edge_no;
            if (btn_press[i])   press_cnt[i]++;
            if (btn_release[i]) rel_cnt[i]++;
        end
        prev_lvl = btn_level;
    endtask

    task automatic steps(input logic [NB-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw);
    endtask

    // Asynchronous reset pulse starting between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_level",   {27'd0, btn_level},   32'd0);
        check("rst_press",   {27'd0, btn_press},   32'd0);
        check("rst_release", {27'd0, btn_release}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_lvl = '0;
    endtask

    logic [NB-1:0] raw_v;
    logic [NB-1:0] mask;
    logic [6:0]    bounce_pat;

    initial begin
        model_reset();
        btn_raw = 5'h1f;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("in_rst_level", {27'd0, btn_level}, 32'd0);
        rst = 1'b0;
        watch_start();

        // idle hold
        steps(5'h1f, 100);
        check("idle_level", {27'd0, btn_level}, 32'd0);
        check("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4], 32'd0);

        // single press on channel 0
        watch_start();
        steps(5'h1e, 12);
        check("p0_rise_edge", rise_edge[0], 32'd7);
        check("p0_press_cnt", press_cnt[0], EXP_PULSES);
        check("p0_others", rise_edge[1] + rise_edge[2] + rise_edge[3] + rise_edge[4], 32'd0);
        steps(5'h1f, 12);

        // bounce on channel 1: pattern 0,0,1,0,0,0,1 then held 0
        watch_start();
        bounce_pat = 7'b1000100;  // bit k = raw at edge k+1
        for (int k = 0; k < 7; k++) begin
            raw_v    = 5'h1f;
            raw_v[1] = bounce_pat[k];
            step(raw_v);
        end
        steps(5'h1d, 13);
        check("b1_rise_edge", rise_edge[1], 32'd14);
        check("b1_press_cnt", press_cnt[1], EXP_PULSES);
        steps(5'h1f, 12);

        // release on channel 2
        steps(5'h1b, 12);
        check("r2_level_up", {31'd0, btn_level[2]}, 32'd1);
        watch_start();
        steps(5'h1f, 12);
        check("r2_fall_edge", fall_edge[2], 32'd7);
        check("r2_rel_cnt", rel_cnt[2], EXP_PULSES);

        // 2-cycle release glitch must be rejected
        steps(5'h1b, 12);
        watch_start();
        steps(5'h1f, 2);
        steps(5'h1b, 12);
        check("g2_fall", fall_edge[2], 32'd0);
        check("g2_pulses", press_cnt[2] + rel_cnt[2], 32'd0);
        check("g2_level", {31'd0, btn_level[2]}, 32'd1);

        // asynchronous reset while pressed
        do_reset();
        steps(5'h1f, 12);

        // simultaneous press on channels 0 and 4
        watch_start();
        steps(5'h0e, 12);
        check("s0_rise_edge", rise_edge[0], 32'd7);
        check("s4_rise_edge", rise_edge[4], 32'd7);
        check("s0_press_cnt", press_cnt[0], EXP_PULSES);
        check("s4_press_cnt", press_cnt[4], EXP_PULSES);
        steps(5'h1f, 12);

        // reset during press qualification, then full requalification
        watch_start();
        steps(5'h1e, 5);
        check("mq_no_press", press_cnt[0], 32'd0);
        do_reset();
        watch_start();
        steps(5'h1e, 12);
        check("mq_rise_edge", rise_edge[0], 32'd7);
        check("mq_press_cnt", press_cnt[0], EXP_PULSES);
        steps(5'h1f, 12);

        // randomized traffic against the model
        raw_v = 5'h1f;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(399, 0) == 0) begin
                do_reset();
            end else begin
                mask = '0;
                for (int i = 0; i < NB; i++) begin
                    if ($urandom_range(5, 0) == 0) mask[i] = 1'b1;
                end
                raw_v = raw_v ^ mask;
                step(raw_v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
